// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: round-robin N-to-1 OBI arbiter with an in-order ID FIFO that routes responses back to the requester.
package obi_rr_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;
  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_rr_arbiter
  import obi_rr_pkg::*;
#(
  parameter int NumMasters     = 3,
  parameter int MaxOutstanding = 2,
  localparam int IdxW          = $clog2(NumMasters),
  localparam int CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  obi_req_t  [NumMasters-1:0] master_req_i,
  output obi_resp_t [NumMasters-1:0] master_resp_o,
  output obi_req_t                   slave_req_o,
  input  obi_resp_t                  slave_resp_i,
  output logic      [CntW-1:0]       outstanding_o,
  output logic                       err_o
);
  localparam int PtrW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
  typedef enum logic {UNLOCKED, LOCKED} lock_e;
  lock_e           state_q, state_d;
  logic [IdxW-1:0] rr_q, lock_idx_q, sel, head;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            err_q, sel_valid, full, push, pop, lock_q;
  int              k;

  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return p == PtrW'(MaxOutstanding - 1) ? '0 : p + 1'b1;
  endfunction

  assign lock_q        = state_q == LOCKED;
  assign full          = cnt_q == CntW'(MaxOutstanding);
  assign head          = fifo_q[rptr_q];
  assign push          = slave_req_o.req & slave_resp_i.gnt;
  assign pop           = slave_resp_i.rvalid & (cnt_q != '0);
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  // Descending scan so the requester closest to rr_q is the last to be written and wins.
  always_comb begin
    sel       = lock_idx_q;
    sel_valid = lock_q;
    k         = 0;
    if (!lock_q)
      for (int i = NumMasters - 1; i >= 0; i--) begin
        k = (int'(rr_q) + i) % NumMasters;
        if (master_req_i[k].req) begin
          sel_valid = 1'b1;
          sel       = IdxW'(k);
        end
      end
  end

  // While locked the locked master's fields stay on the bus even if it drops req.
  always_comb begin
    slave_req_o = '0;
    if (sel_valid) begin
      slave_req_o     = master_req_i[sel];
      slave_req_o.req = master_req_i[sel].req & ~full;
    end
  end

  always_comb begin
    master_resp_o          = '0;
    master_resp_o[sel].gnt = push;
    if (pop) begin
      master_resp_o[head].rvalid = 1'b1;
      master_resp_o[head].rdata  = slave_resp_i.rdata;
    end
  end

  always_comb
    state_d = push ? UNLOCKED : (slave_req_o.req & ~slave_resp_i.gnt) ? LOCKED : state_q;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q    <= UNLOCKED;
      lock_idx_q <= '0;
      rr_q       <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (slave_req_o.req & ~slave_resp_i.gnt) lock_idx_q <= sel;
      if (push) begin
        rr_q   <= sel == IdxW'(NumMasters - 1) ? '0 : sel + 1'b1;
        wptr_q <= nxt(wptr_q);
      end
      if (pop) rptr_q <= nxt(rptr_q);
      cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
      err_q <= err_q | (slave_resp_i.rvalid & (cnt_q == '0));
    end

  always_ff @(posedge clk_i)
    if (push) fifo_q[wptr_q] <= sel;
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// tb_obi_rr_arbiter: directed plan scenarios plus random traffic, checked each cycle against a queue-based model.
module tb_obi_rr_arbiter;
  import obi_rr_pkg::*;
  localparam int N = 3;
  localparam int M = 2;
  logic clk = 0;
  logic rst = 1;
  obi_req_t  [N-1:0] mreq;
  obi_resp_t [N-1:0] mresp;
  obi_req_t          sreq;
  obi_resp_t         sresp;
  logic [1:0]        outstanding;
  logic              err;
  int total = 0;
  int bad = 0;
  int mq[$];
  int m_rr, m_lock, m_lidx;
  bit m_err;

  always #5 clk = ~clk;

  obi_rr_arbiter #(.NumMasters(N), .MaxOutstanding(M)) dut (
    .clk_i(clk), .rst_i(rst), .master_req_i(mreq), .master_resp_o(mresp),
    .slave_req_o(sreq), .slave_resp_i(sresp), .outstanding_o(outstanding), .err_o(err)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic logic [N-1:0] gnts();
    logic [N-1:0] g;
    for (int i = 0; i < N; i++) g[i] = mresp[i].gnt;
    return g;
  endfunction

  function automatic logic [N-1:0] rvs();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = mresp[i].rvalid;
    return r;
  endfunction

  task automatic model_check();
    int sel;
    bit selv, rq, popping;
    obi_req_t es;
    obi_resp_t [N-1:0] er;
    sel = 0;
    selv = 0;
    if (m_lock != 0) begin
      sel = m_lidx;
      selv = 1;
    end else
      for (int i = 0; i < N; i++)
        if (!selv && mreq[(m_rr + i) % N].req) begin
          sel = (m_rr + i) % N;
          selv = 1;
        end
    rq = selv && mreq[sel].req && mq.size() < M;
    es = selv ? mreq[sel] : '0;
    es.req = rq;
    er = '0;
    if (rq && sresp.gnt) er[sel].gnt = 1'b1;
    popping = sresp.rvalid && mq.size() > 0;
    if (popping) begin
      er[mq[0]].rvalid = 1'b1;
      er[mq[0]].rdata = sresp.rdata;
    end
    chk("slave_req", sreq, es);
    for (int i = 0; i < N; i++) chk($sformatf("master_resp%0d", i), mresp[i], er[i]);
    chk("outstanding", outstanding, mq.size());
    chk("err", err, m_err);
    if (sresp.rvalid && mq.size() == 0) m_err = 1;
    if (popping) void'(mq.pop_front());
    if (rq && sresp.gnt) begin
      mq.push_back(sel);
      m_rr = (sel + 1) % N;
      m_lock = 0;
    end else if (rq) begin
      m_lock = 1;
      m_lidx = sel;
    end
  endtask

  task automatic step(input logic [N-1:0] rq, input logic g, input logic rv, input logic [31:0] rd);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      mreq[i].req = rq[i];
      mreq[i].we = 1'(i % 2);
      mreq[i].be = 4'hF;
      mreq[i].addr = 32'h1000 + 32'(16 * i);
      mreq[i].wdata = 32'hD0 + 32'(i);
    end
    sresp.gnt = g;
    sresp.rvalid = rv;
    sresp.rdata = rd;
    #5 model_check();
  endtask

  task automatic rstep();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      mreq[i].req = $urandom_range(0, 9) < 6;
      mreq[i].we = 1'($urandom);
      mreq[i].be = 4'($urandom);
      mreq[i].addr = $urandom;
      mreq[i].wdata = $urandom;
    end
    sresp.gnt = 1'($urandom);
    sresp.rvalid = mq.size() > 0 ? 1'($urandom) : $urandom_range(0, 199) == 0;
    sresp.rdata = $urandom;
    #5 model_check();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1;
    #1;
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err, 0);
    mq.delete();
    m_rr = 0;
    m_lock = 0;
    m_lidx = 0;
    m_err = 0;
    mreq = '0;
    sresp = '0;
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    mreq = '0;
    sresp = '0;
    m_rr = 0;
    m_lock = 0;
    m_lidx = 0;
    m_err = 0;
    @(posedge clk);
    #1;
    chk("reset_outstanding", outstanding, 0);
    chk("reset_err", err, 0);
    chk("reset_slave_req", sreq, 0);
    chk("reset_gnt", gnts(), 0);
    chk("reset_rvalid", rvs(), 0);
    rst = 0;
    // simultaneous requests
    step(3'b111, 1, 0, 0);       chk("sim_gnt0", gnts(), 3'b001);
    step(3'b110, 1, 1, 32'hA0);  chk("sim_gnt1", gnts(), 3'b010);
    chk("sim_rv0", rvs(), 3'b001); chk("sim_rdata0", mresp[0].rdata, 32'hA0);
    step(3'b100, 1, 1, 32'hA1);  chk("sim_gnt2", gnts(), 3'b100);
    chk("sim_rv1", rvs(), 3'b010); chk("sim_rdata1", mresp[1].rdata, 32'hA1);
    step(3'b000, 1, 1, 32'hA2);  chk("sim_rv2", rvs(), 3'b100);
    chk("sim_rdata2", mresp[2].rdata, 32'hA2); chk("sim_out", outstanding, 1);
    step(3'b000, 0, 0, 0);       chk("sim_drained", outstanding, 0);
    // rotation after master 2
    step(3'b101, 1, 0, 0);       chk("rot_gnt0", gnts(), 3'b001);
    step(3'b100, 1, 1, 32'hB0);  chk("rot_gnt2", gnts(), 3'b100);
    step(3'b000, 0, 1, 32'hB2);  chk("rot_rv2", rvs(), 3'b100);
    // lock on master 1 while master 0 joins
    step(3'b010, 0, 0, 0);       chk("lock_addr0", sreq.addr, 32'h1010); chk("lock_req", sreq.req, 1);
    step(3'b011, 0, 0, 0);       chk("lock_addr1", sreq.addr, 32'h1010);
    step(3'b011, 0, 0, 0);       chk("lock_addr2", sreq.addr, 32'h1010); chk("lock_nognt", gnts(), 0);
    step(3'b011, 1, 0, 0);       chk("lock_gnt1", gnts(), 3'b010);
    step(3'b001, 1, 0, 0);       chk("lock_gnt0", gnts(), 3'b001);
    step(3'b000, 0, 1, 32'h1);   chk("lock_rv1", rvs(), 3'b010);
    step(3'b000, 0, 1, 32'h2);   chk("lock_rv0", rvs(), 3'b001);
    // full FIFO
    step(3'b111, 1, 0, 0);       chk("full_gnt1", gnts(), 3'b010);
    step(3'b101, 1, 0, 0);       chk("full_gnt2", gnts(), 3'b100);
    step(3'b101, 1, 0, 0);       chk("full_req", sreq.req, 0); chk("full_out", outstanding, 2);
    chk("full_nognt", gnts(), 0);
    step(3'b101, 1, 1, 32'hC1);  chk("full_pop_nognt", gnts(), 0); chk("full_rv1", rvs(), 3'b010);
    step(3'b101, 1, 0, 0);       chk("full_release", gnts(), 3'b001); chk("full_out1", outstanding, 1);
    step(3'b101, 1, 0, 0);       chk("full_again", gnts(), 0);
    // reset with two outstanding, then rr must restart at 0
    do_reset();
    step(3'b111, 1, 0, 0);       chk("rst_rr0", gnts(), 3'b001);
    step(3'b000, 0, 1, 32'h7);   chk("rst_rv0", rvs(), 3'b001);
    // spurious response
    step(3'b000, 0, 1, 32'h55);  chk("spur_rv", rvs(), 0); chk("spur_err_pre", err, 0);
    step(3'b000, 0, 0, 0);       chk("spur_err", err, 1);
    for (int i = 0; i < 20; i++) rstep();
    chk("spur_sticky", err, 1);
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      rstep();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/obi_rr_arbiter.md
# obi_rr_arbiter

- Round-robin N-to-1 OBI arbiter that shares one slave-side OBI port among `NumMasters` requesters.
- Tracks up to `MaxOutstanding` granted-but-unanswered transactions in an in-order ID FIFO, so each `rvalid`/`rdata` returns to the master that issued the request.
- Sits in front of the 1-to-M address-decoding stage of the system bus (one-to-M bus topology), or in front of any single shared OBI slave.

## Interface

Parameters:
- `NumMasters`, default 3: number of requesting OBI masters (≥2).
- `MaxOutstanding`, default 2: ID FIFO depth, i.e. the maximum number of granted transactions awaiting `rvalid` (≥1).
- `IdxW` (localparam): `$clog2(NumMasters)`.
- `CntW` (localparam): `$clog2(MaxOutstanding+1)`.

Ports:
- `clk_i`, in, 1: clock; single clock domain.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `master_req_i`, in, `obi_req_t [NumMasters-1:0]`: per-master `req`, `we`, `be`, `addr`, `wdata`.
- `master_resp_o`, out, `obi_resp_t [NumMasters-1:0]`: per-master `gnt`, `rvalid`, `rdata`.
- `slave_req_o`, out, `obi_req_t`: arbitrated request to the shared slave.
- `slave_resp_i`, in, `obi_resp_t`: shared slave response.
- `outstanding_o`, out, `CntW`: current ID FIFO occupancy.
- `err_o`, out, 1: sticky flag, set when `rvalid` arrives with the FIFO empty.

## Operation

Registered state:
- `rr_q`: round-robin pointer, `IdxW` bits.
- `lock_q`: 1 bit; `lock_idx_q`: `IdxW` bits.
- ID FIFO: `MaxOutstanding` entries of `IdxW` bits, with read and write pointers and count `cnt_q`.
- `err_q`.

Arbitration:
- When unlocked, select the first master with `req=1`, searching from index `rr_q` upward and wrapping modulo `NumMasters`.
- When `lock_q=1`, the selection is forced to `lock_idx_q`, regardless of other requests.

Issue:
- `full = (cnt_q == MaxOutstanding)`.
- `slave_req_o.req = sel_valid & ~full`.
- `slave_req_o.{we,be,addr,wdata}` = selected master's fields; all zero when nothing is selected.

Grant:
- `master_resp_o[sel].gnt = slave_resp_i.gnt & slave_req_o.req`.
- All other masters see `gnt=0`.
- On a handshake (`slave_req_o.req & slave_resp_i.gnt`):
  - push `sel` into the FIFO;
  - set `rr_q <= (sel+1) mod NumMasters`;
  - clear `lock_q`.

Lock state machine (two states):
- UNLOCKED → LOCKED when `slave_req_o.req=1` and `gnt=0`; `lock_idx_q <= sel`.
  - This keeps the slave-side address phase stable until it is granted, as OBI requires.
- LOCKED → UNLOCKED on a handshake.
- While LOCKED, `rr_q` does not move.

Response routing:
- When `slave_resp_i.rvalid=1` and `cnt_q>0`, drive `master_resp_o[head].rvalid=1` and `master_resp_o[head].rdata = slave_resp_i.rdata`, then pop the FIFO.
- Every other master sees `rvalid=0` and `rdata=0`.

Boundary conditions:
- **Full:** no request is issued and no grant is given. The lock does not engage, because `req` is low.
- **Push and pop in the same cycle:** `cnt_q` is unchanged and both pointers advance.
- **Push and pop in the same cycle while full:** the push is blocked because `full` uses the registered `cnt_q`; only the pop happens.
- **Pointer wrap:** FIFO pointers wrap modulo `MaxOutstanding`, which need not be a power of two. `rr_q` wraps from `NumMasters-1` to 0.
- **`rvalid` with `cnt_q==0`:** the response is dropped, no master sees it, and `err_q <= 1`. Only reset clears `err_q`.
- **A master drops `req` while locked to it** (OBI violation): the lock is held and `slave_req_o.req` follows the master's `req`.

## Timing

- Request, grant and response paths are combinational, giving zero added latency. There is no combinational path from `slave_resp_i.gnt` to `slave_req_o.req`.
- The handshake updates the FIFO, `rr_q` and the lock at the next rising edge.
- `outstanding_o = cnt_q`; `err_o = err_q`.
- Reset (asynchronous assert, synchronous deassert at system level):
  - `rr_q=0`, `lock_q=0`, `lock_idx_q=0`, FIFO empty, `cnt_q=0`, `err_q=0`.
  - Consequently `outstanding_o=0` and `err_o=0`; with no requests pending, every `gnt`, `rvalid`, `rdata` and slave request field is 0.
- Reset mid-transaction discards all outstanding IDs. Any later `rvalid` for those transactions sets `err_o`.

## Test plan

- **Simultaneous requests:** masters 0, 1 and 2 request together; slave holds `gnt=1` and returns `rvalid` one cycle after each grant. Required: grants go to 0, 1, 2 in consecutive cycles; rdata `0xA0`, `0xA1`, `0xA2` route back to 0, 1, 2; `outstanding_o` never exceeds 2.
- **Round-robin rotation:** master 2 is granted, then masters 0 and 2 request. Required: master 0 is granted next, then master 2.
- **Lock:** slave holds `gnt=0` for 3 cycles while master 1 is selected, and master 0 starts requesting in cycle 2. Required: `slave_req_o.addr` equals master 1's address for all 3 cycles; master 1 is granted first.
- **Full FIFO:** `MaxOutstanding=2`, slave withholds `rvalid`. Required: after 2 grants, `slave_req_o.req=0` and `outstanding_o=2`. One `rvalid` releases exactly one new grant on the following cycle.
- **Spurious response:** drive `rvalid=1` with the FIFO empty. Required: `err_o=1` from the next cycle, no master sees `rvalid`, and `err_o` stays 1 until `rst_i` is asserted.
- **Reset mid-operation:** assert `rst_i` with 2 transactions outstanding. Required: `outstanding_o=0` immediately and `rr_q` returns to 0.
